// File: rtl/fetch_ifid.sv
// rtl/fetch_ifid.sv - fetch stage with PC ownership and IF/ID pipeline register
module fetch_ifid #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_ready,
  output logic [15:0] FD_instr,
  output logic [15:0] FD_pcPlus2,
  output logic        FD_valid,
  output logic        halted
);

  typedef enum logic {S_FETCH = 1'b0, S_HALTED = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_pc;
  logic [15:0] r_fd_instr;
  logic [15:0] r_fd_pc_plus2;
  logic        r_fd_valid;

  logic [15:0] w_pc_next;
  logic [15:0] w_fd_instr_next;
  logic [15:0] w_fd_pc_plus2_next;
  logic        w_fd_valid_next;
  logic [15:0] w_pc_plus2;
  logic        w_is_halt;
  logic        w_accept;

  assign w_pc_plus2 = r_pc + 16'd2;
  assign w_is_halt  = (imem_data[15:11] == 5'b00000);
  // A fetched word is consumed only in FETCH with no flush/stall and memory ready.
  assign w_accept   = !flush && !stall && (r_state == S_FETCH) && imem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_FETCH;
    end else if (w_accept && w_is_halt) begin
      w_state_next = S_HALTED;
    end
  end

  always_comb begin
    halted = (r_state == S_HALTED);
  end

  always_comb begin
    w_pc_next          = r_pc;
    w_fd_instr_next    = r_fd_instr;
    w_fd_pc_plus2_next = r_fd_pc_plus2;
    w_fd_valid_next    = r_fd_valid;
    if (flush) begin
      w_pc_next       = redirect_pc;
      w_fd_instr_next = NOP_INSTR;
      w_fd_valid_next = 1'b0;
    end else if (stall) begin
      w_pc_next = r_pc;
    end else if (!w_accept) begin
      // Decode keeps advancing, so HALTED and memory wait states feed bubbles.
      w_fd_instr_next = NOP_INSTR;
      w_fd_valid_next = 1'b0;
    end else begin
      w_fd_instr_next    = imem_data;
      w_fd_pc_plus2_next = w_pc_plus2;
      w_fd_valid_next    = 1'b1;
      w_pc_next          = w_is_halt ? r_pc : w_pc_plus2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_fd_instr    <= NOP_INSTR;
      r_fd_pc_plus2 <= 16'h0000;
      r_fd_valid    <= 1'b0;
    end else begin
      r_pc          <= w_pc_next;
      r_fd_instr    <= w_fd_instr_next;
      r_fd_pc_plus2 <= w_fd_pc_plus2_next;
      r_fd_valid    <= w_fd_valid_next;
    end
  end

  assign imem_addr  = r_pc;
  assign FD_instr   = r_fd_instr;
  assign FD_pcPlus2 = r_fd_pc_plus2;
  assign FD_valid   = r_fd_valid;

endmodule

// File: tb/tb_fetch_ifid.sv
// tb/tb_fetch_ifid.sv - directed self-checking bench for fetch_ifid
module tb_fetch_ifid;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_ready;
  logic [15:0] FD_instr;
  logic [15:0] FD_pcPlus2;
  logic        FD_valid;
  logic        halted;

  int n_tests;
  int n_fail;

  fetch_ifid dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_ready (imem_ready),
    .FD_instr   (FD_instr),
    .FD_pcPlus2 (FD_pcPlus2),
    .FD_valid   (FD_valid),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 16'h4000;
      16'h0002: mem_word = 16'h4100;
      16'h0004: mem_word = 16'h4200;
      16'h0006: mem_word = 16'h4300;
      16'h0008: mem_word = 16'h0000;
      16'h0010: mem_word = 16'h4500;
      16'h0040: mem_word = 16'h4400;
      16'hFFFE: mem_word = 16'h4700;
      default:  mem_word = 16'h4800;
    endcase
  endfunction

  // Not-ready data is a HALT-looking word so ignoring imem_ready shows up.
  assign imem_data = imem_ready ? mem_word(imem_addr) : 16'h0000;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_fd(input string tag, input logic [15:0] addr, input logic [15:0] instr,
                          input logic [15:0] pcp2, input logic valid, input logic hlt);
    check({tag, ".addr"},   imem_addr, addr);
    check({tag, ".instr"},  FD_instr, instr);
    check({tag, ".pcp2"},   FD_pcPlus2, pcp2);
    check({tag, ".valid"},  {15'd0, FD_valid}, {15'd0, valid});
    check({tag, ".halted"}, {15'd0, halted}, {15'd0, hlt});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 16'h0000; imem_ready = 1'b0;
    #2;
    check_fd("reset_async", 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b1;

    step(); check_fd("seq0", 16'h0002, 16'h4000, 16'h0002, 1'b1, 1'b0);
    step(); check_fd("seq1", 16'h0004, 16'h4100, 16'h0004, 1'b1, 1'b0);

    stall = 1'b1;
    step(); check_fd("stall0", 16'h0004, 16'h4100, 16'h0004, 1'b1, 1'b0);
    step(); check_fd("stall1", 16'h0004, 16'h4100, 16'h0004, 1'b1, 1'b0);
    stall = 1'b0;
    step(); check_fd("seq2", 16'h0006, 16'h4200, 16'h0006, 1'b1, 1'b0);

    stall = 1'b1; flush = 1'b1; redirect_pc = 16'h0040;
    step(); check_fd("flush_stall", 16'h0040, 16'h0800, 16'h0006, 1'b0, 1'b0);
    stall = 1'b0; flush = 1'b0;
    step(); check_fd("after_flush", 16'h0042, 16'h4400, 16'h0042, 1'b1, 1'b0);

    flush = 1'b1; redirect_pc = 16'h0008;
    step(); check_fd("to_halt", 16'h0008, 16'h0800, 16'h0042, 1'b0, 1'b0);
    flush = 1'b0; stall = 1'b1;
    step(); check_fd("halt_stalled", 16'h0008, 16'h0800, 16'h0042, 1'b0, 1'b0);
    stall = 1'b0;
    step(); check_fd("halt_fetch", 16'h0008, 16'h0000, 16'h000A, 1'b1, 1'b1);
    step(); check_fd("halted0", 16'h0008, 16'h0800, 16'h000A, 1'b0, 1'b1);
    step(); check_fd("halted1", 16'h0008, 16'h0800, 16'h000A, 1'b0, 1'b1);
    flush = 1'b1; redirect_pc = 16'h0010;
    step(); check_fd("resume", 16'h0010, 16'h0800, 16'h000A, 1'b0, 1'b0);
    flush = 1'b0;
    step(); check_fd("resume_fetch", 16'h0012, 16'h4500, 16'h0012, 1'b1, 1'b0);

    rst = 1'b1;
    #2;
    check_fd("reset_mid", 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(); check_fd("wait_pre", 16'h0002, 16'h4000, 16'h0002, 1'b1, 1'b0);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check_fd($sformatf("wait%0d", i), 16'h0002, 16'h0800, 16'h0002, 1'b0, 1'b0);
    end
    rst = 1'b1;
    #2;
    check_fd("reset_wait", 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b1;

    flush = 1'b1; redirect_pc = 16'hFFFE;
    step(); check_fd("wrap_redir", 16'hFFFE, 16'h0800, 16'h0000, 1'b0, 1'b0);
    flush = 1'b0;
    step(); check_fd("wrap_fetch", 16'h0000, 16'h4700, 16'h0000, 1'b1, 1'b0);
    step(); check_fd("wrap_next", 16'h0002, 16'h4000, 16'h0002, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ifid.md
Name: fetch_ifid

Overview:
- Fetch stage plus IF/ID pipeline register, sitting directly upstream of decode.
- Owns the PC and drives the instruction-memory address.
- Latches the fetched instruction, PC+2 and a valid bit into the IF/ID register for decode.
- Handles hazard stalls, control-flow flushes/redirects, memory wait states and HALT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INSTR, 16'h0800, bubble instruction inserted into IF/ID (opcode 00001).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
stall  input  1  hazard unit request: hold PC and IF/ID.
flush  input  1  taken branch/jump resolved downstream; squash IF/ID and redirect.
redirect_pc  input  16  target PC, used when flush=1.
imem_addr  output  16  instruction memory address; equals current PC, combinational.
imem_data  input  16  instruction word for imem_addr.
imem_ready  input  1  imem_data is valid this cycle.
FD_instr  output  16  registered instruction to decode.
FD_pcPlus2  output  16  registered PC+2 of FD_instr.
FD_valid  output  1  FD_instr is a real instruction; drives decode valid.
halted  output  1  HALT fetched; fetch frozen.

Behaviour:
- Reset: the polarity and synchronicity here are fixed; one clock (clk); reset (rst) is asynchronous and active-high. On rst, immediately and regardless of clk: pc=RESET_PC, FD_instr=NOP_INSTR, FD_pcPlus2=0, FD_valid=0, halted=0, state=FETCH. Reset mid-stall, mid-wait or while HALTED fully restarts fetch.
- State machine: FETCH and HALTED. halted=1 exactly in HALTED.
- imem_addr = pc at all times, including in HALTED.
- Arithmetic: pc+2 is 16-bit unsigned with wrap (16'hFFFE+2 = 16'h0000). redirect_pc is taken as-is; no alignment check.
- Per-edge priority, highest first:
  1. flush=1, any state, ignores stall and imem_ready: pc<=redirect_pc; FD_instr<=NOP_INSTR; FD_pcPlus2 holds; FD_valid<=0; state<=FETCH. This clears a speculatively fetched HALT.
  2. stall=1: pc and all FD_* hold; state holds.
  3. state=HALTED: pc holds; FD_instr<=NOP_INSTR; FD_valid<=0.
  4. imem_ready=0 (FETCH): pc holds; FD_instr<=NOP_INSTR; FD_valid<=0. A bubble is inserted because decode advances.
  5. imem_ready=1 (FETCH): FD_instr<=imem_data; FD_pcPlus2<=pc+2; FD_valid<=1.
     - If imem_data[15:11]==5'b00000 (HALT): pc holds; state<=HALTED. The HALT word itself is delivered valid to decode.
     - Otherwise: pc<=pc+2.
- Latency: instruction at pc appears on FD_instr one edge after imem_ready=1 with no stall and no flush.
- Throughput: one instruction per cycle.
- Simultaneous stall and flush: flush wins; the squashed instruction is never delivered.
- A HALT fetched while stall=1 is not latched; it is re-presented after the stall releases.
- No combinational path from imem_data to any output.

Test Plan:
- Reset, then imem_ready=1 with memory words 0x4000@0, 0x4100@2, 0x4200@4 -> FD_instr = 0x4000, 0x4100, 0x4200 on consecutive edges; FD_pcPlus2 = 2, 4, 6; FD_valid=1; FD_* reset values checked asynchronously before the first edge.
- stall=1 for 2 cycles while pc=4 -> FD_instr stays 0x4100, imem_addr stays 4; after release, 0x4200 arrives with FD_pcPlus2=6.
- flush=1 with redirect_pc=0x0040 and stall=1 in the same cycle -> next edge: imem_addr=0x0040, FD_instr=0x0800, FD_valid=0; following edge: word@0x40 with FD_pcPlus2=0x0042.
- HALT (0x0000) at pc=0x0008 -> FD_instr=0x0000 valid for one cycle, then NOP with FD_valid=0; halted=1; imem_addr frozen at 8. A later flush to 0x0010 resumes fetch and halted=0.
- imem_ready=0 for 3 cycles at pc=0x0002 -> three NOP bubbles with FD_valid=0 and pc held; rst pulsed mid-wait -> immediate async return to pc=0, FD_valid=0.
- Wrap case: redirect to 0xFFFE, then fetch -> FD_pcPlus2=0x0000 and next imem_addr=0x0000.
